// File: rtl/updown_count_monitor_pkg.sv
// Package for the up/down counter monitor.
// Holds the FSM state encoding, the error counter width and the shared
// next-count prediction used by the predictor.
package updown_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } mon_state_e;

    localparam int ERR_W     = 8;
    // Carrier width for next_count. It must be larger than any counter width W.
    localparam int CNT_MAX_W = 31;

    // Next value of a w-bit up/down counter. A counter reset takes priority
    // over the direction. The result wraps modulo 2**w.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] val,
        input logic                 up,
        input logic                 rst,
        input int                   w
    );
        logic [CNT_MAX_W-1:0] mask;
        logic [CNT_MAX_W-1:0] sum;
        mask = CNT_MAX_W'((64'd1 << w) - 64'd1);
        if (rst)     sum = '0;
        else if (up) sum = val + CNT_MAX_W'(1);
        else         sum = val - CNT_MAX_W'(1);
        return sum & mask;
    endfunction

endpackage

// File: rtl/updown_count_monitor_if.sv
// Bus between the observed counter/control side and the monitor.
//   master : drives the sampled counter signals and the controls (en, clr).
//   slave  : the monitor. It takes those signals in and drives the status
//            signals out: locked, fault, err, err_cnt, dir, wrap_up, wrap_dn.
interface updown_count_monitor_if
    import updown_mon_pkg::*;
#(
    parameter int W      = 3,
    parameter int WRAP_W = 16
);
    logic              en;
    logic              cnt_rst;
    logic              cnt_up;
    logic [W-1:0]      cnt_val;
    logic              clr;
    logic              locked;
    logic              fault;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;
    logic              dir;
    logic [WRAP_W-1:0] wrap_up;
    logic [WRAP_W-1:0] wrap_dn;

    modport master (
        output en, cnt_rst, cnt_up, cnt_val, clr,
        input  locked, fault, err, err_cnt, dir, wrap_up, wrap_dn
    );

    modport slave (
        input  en, cnt_rst, cnt_up, cnt_val, clr,
        output locked, fault, err, err_cnt, dir, wrap_up, wrap_dn
    );
endinterface

// File: rtl/updown_count_monitor_predictor.sv
// count_predictor: holds the expected next count and the step behind it.
//   clk, reset      : clock and asynchronous active-low reset
//   upd             : load a new prediction from this sample
//   cnt_rst/up/val  : the observed counter signals
//   match           : the observed value equals the armed prediction
//   step_up/rst     : direction and reset flag of the predicted step
//   is_wrap_up/dn   : the predicted step is a wrap (reset steps never are)
module count_predictor
    import updown_mon_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         upd,
    input  logic         cnt_rst,
    input  logic         cnt_up,
    input  logic [W-1:0] cnt_val,
    output logic         match,
    output logic         step_up,
    output logic         step_rst,
    output logic         is_wrap_up,
    output logic         is_wrap_dn
);
    logic [W-1:0] exp_q;
    logic [W-1:0] prev_val;
    logic [W-1:0] nxt;

    assign nxt = W'(next_count(CNT_MAX_W'(cnt_val), cnt_up, cnt_rst, W));

    // The prediction always resyncs from the observed value, even after a mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q    <= '0;
            prev_val <= '0;
            step_up  <= 1'b0;
            step_rst <= 1'b0;
        end else if (upd) begin
            exp_q    <= nxt;
            prev_val <= cnt_val;
            step_up  <= cnt_up;
            step_rst <= cnt_rst;
        end
    end

    assign match      = (cnt_val == exp_q);
    assign is_wrap_up = step_up  && !step_rst && (prev_val == {W{1'b1}});
    assign is_wrap_dn = !step_up && !step_rst && (prev_val == '0);
endmodule

// File: rtl/updown_count_monitor.sv
// updown_count_monitor: passive checker for a W-bit up/down counter.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : slave modport. The counter signals and the en/clr controls come in.
//           The status signals go out: locked, fault, err, err_cnt, dir, wraps.
// The predictor arms an expected value. This module runs the
// UNLOCKED/LOCKED/FAULT FSM and holds the error and wrap counters.
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int W       = 3,
    parameter int MAX_ERR = 4,
    parameter int WRAP_W  = 16
) (
    input logic                   clk,
    input logic                   reset,
    updown_count_monitor_if.slave bus
);
    localparam logic [ERR_W:0] MAX_ERR_L = (ERR_W+1)'(MAX_ERR);

    mon_state_e        state_q, state_d;
    logic              match, step_up, step_rst, is_wrap_up, is_wrap_dn;
    logic              upd, hit, miss;
    logic              err_q, dir_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ERR_W:0]    err_inc;
    logic [WRAP_W-1:0] wrap_up_q, wrap_dn_q;

    // The prediction is frozen in FAULT. Compares happen only while LOCKED.
    assign upd     = bus.en && (state_q != FAULT);
    assign hit     = bus.en && (state_q == LOCKED) && match;
    assign miss    = bus.en && (state_q == LOCKED) && !match;
    assign err_inc = {1'b0, err_cnt_q} + (ERR_W+1)'(1);

    count_predictor #(.W(W)) u_pred (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd),
        .cnt_rst    (bus.cnt_rst),
        .cnt_up     (bus.cnt_up),
        .cnt_val    (bus.cnt_val),
        .match      (match),
        .step_up    (step_up),
        .step_rst   (step_rst),
        .is_wrap_up (is_wrap_up),
        .is_wrap_dn (is_wrap_dn)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= UNLOCKED;
        else        state_q <= state_d;
    end

    // If clr arrives on the same edge as a fatal mismatch, it zeroes err_cnt,
    // so the monitor stays LOCKED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (bus.en) state_d = LOCKED;
            LOCKED:   if (miss && !bus.clr && (err_inc >= MAX_ERR_L)) state_d = FAULT;
            FAULT:    if (bus.clr) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q     <= 1'b0;
            dir_q     <= 1'b0;
            err_cnt_q <= '0;
            wrap_up_q <= '0;
            wrap_dn_q <= '0;
        end else begin
            err_q <= miss;
            // Credit the step that was predicted on the previous edge.
            if (hit && !step_rst) dir_q <= step_up;
            if (bus.clr) begin
                err_cnt_q <= '0;
                wrap_up_q <= '0;
                wrap_dn_q <= '0;
            end else begin
                if (miss && (err_cnt_q != '1))
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                if (hit && is_wrap_up && (wrap_up_q != '1))
                    wrap_up_q <= wrap_up_q + WRAP_W'(1);
                if (hit && is_wrap_dn && (wrap_dn_q != '1))
                    wrap_dn_q <= wrap_dn_q + WRAP_W'(1);
            end
        end
    end

    assign bus.locked  = (state_q == LOCKED);
    assign bus.fault   = (state_q == FAULT);
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.dir     = dir_q;
    assign bus.wrap_up = wrap_up_q;
    assign bus.wrap_dn = wrap_dn_q;
endmodule
